// File: rtl/ltl_monitor_sequencer.sv
// Sequences trace symbols into an automaton, captures non-zero report vectors
// with their symbol index into a fall-through FIFO and flags end of each trace.
module ltl_monitor_sequencer #(
  parameter int unsigned NUM_REPORTS = 4,
  parameter int unsigned IDX_W       = 16,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [7:0]             s_data,
  input  logic                   s_first,
  input  logic                   s_last,
  output logic                   am_reset,
  output logic                   am_run,
  output logic [7:0]             am_symbols,
  input  logic [NUM_REPORTS-1:0] am_report,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [NUM_REPORTS-1:0] m_report,
  output logic [IDX_W-1:0]       m_index,
  output logic                   trace_done,
  output logic [IDX_W-1:0]       trace_len,
  output logic                   busy
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned USE_W = CNT_W + 1;
  localparam int unsigned REC_W = NUM_REPORTS + IDX_W;
  localparam logic [IDX_W-1:0] IDX_MAX = '1;

  typedef enum logic [1:0] {IDLE, FLUSH, RUN, DRAIN} state_t;

  state_t             state, state_n;
  logic               flush_seen;
  logic               restart;
  logic               samp;
  logic [IDX_W-1:0]   samp_idx;
  logic [IDX_W-1:0]   index;
  logic               accept_c;
  logic               done_c;
  logic               room_c;
  logic               push_c;
  logic               pop_c;
  logic [USE_W-1:0]   used_c;

  logic [REC_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;

  // Occupancy plus the report sample landing this cycle; keeps room for the
  // symbol already in the automaton and the one being accepted now.
  assign used_c = USE_W'(count) + USE_W'(samp);
  assign room_c = used_c <= USE_W'(FIFO_DEPTH - 2);

  always_comb begin
    state_n = state;
    s_ready = 1'b0;
    case (state)
      IDLE: begin
        if (s_valid) state_n = FLUSH;
      end
      FLUSH: begin
        s_ready = flush_seen && room_c && !reset;
        if (s_valid && s_ready) state_n = s_last ? DRAIN : RUN;
      end
      RUN: begin
        s_ready = room_c && !s_first && !reset;
        if (s_valid && s_first) state_n = DRAIN;
        else if (s_valid && s_ready && s_last) state_n = DRAIN;
      end
      DRAIN: begin
        if (!am_run) state_n = restart ? FLUSH : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign accept_c = s_valid && s_ready;
  // Once am_run is low, the final report sample happens on this edge.
  assign done_c   = (state == DRAIN) && !am_run;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      flush_seen <= 1'b0;
      restart    <= 1'b0;
      am_reset   <= 1'b1;
      am_run     <= 1'b0;
      am_symbols <= '0;
      index      <= '0;
      samp       <= 1'b0;
      samp_idx   <= '0;
      trace_done <= 1'b0;
      trace_len  <= '0;
    end else begin
      state      <= state_n;
      flush_seen <= (state == FLUSH);
      am_reset   <= (state_n == IDLE) || (state_n == FLUSH);
      am_run     <= accept_c;
      if (accept_c) begin
        am_symbols <= s_data;
        if (state == FLUSH) index <= '0;
        else if (index != IDX_MAX) index <= index + IDX_W'(1);
      end
      samp <= am_run;
      if (am_run) samp_idx <= index;
      if (state == RUN && s_valid && s_first) restart <= 1'b1;
      else if (done_c) restart <= 1'b0;
      trace_done <= done_c;
      if (done_c) trace_len <= (index == IDX_MAX) ? IDX_MAX : index + IDX_W'(1);
    end
  end

  assign push_c = samp && (am_report != '0);
  assign pop_c  = m_valid && m_ready;

  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= {am_report, samp_idx};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign m_valid  = (count != '0);
  assign m_report = mem[rd_ptr][REC_W-1:IDX_W];
  assign m_index  = mem[rd_ptr][IDX_W-1:0];

endmodule

// File: tb/tb_ltl_monitor_sequencer.sv
// Bench for ltl_monitor_sequencer: cycle table for a single trace, then
// directed multi-cycle sequences checked against a report scoreboard.
module tb_ltl_monitor_sequencer;

  localparam int unsigned NR = 4;
  localparam int unsigned IW = 4;
  localparam int unsigned FD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          s_valid, s_ready, s_first, s_last;
  logic [7:0]    s_data;
  logic          am_reset, am_run;
  logic [7:0]    am_symbols;
  logic [NR-1:0] am_report;
  logic          m_valid, m_ready;
  logic [NR-1:0] m_report;
  logic [IW-1:0] m_index;
  logic          trace_done;
  logic [IW-1:0] trace_len;
  logic          busy;

  always #5 clk = ~clk;

  ltl_monitor_sequencer #(.NUM_REPORTS(NR), .IDX_W(IW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_first(s_first), .s_last(s_last),
    .am_reset(am_reset), .am_run(am_run), .am_symbols(am_symbols),
    .am_report(am_report),
    .m_valid(m_valid), .m_ready(m_ready), .m_report(m_report), .m_index(m_index),
    .trace_done(trace_done), .trace_len(trace_len), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Automaton stand-in: report register updated on each am_run step.
  int rep_mode = 0;
  function automatic logic [NR-1:0] rep_map(input logic [7:0] sym);
    case (rep_mode)
      0:       return (sym == 8'h20) ? 4'b0010 : 4'b0000;
      1:       return 4'b1000;
      default: return sym[3:0];
    endcase
  endfunction

  always @(posedge clk) begin
    if (am_reset) am_report <= '0;
    else if (am_run) am_report <= rep_map(am_symbols);
  end

  // Scoreboard: expected records are queued at symbol acceptance.
  logic [NR+IW-1:0] exp_q[$];
  logic [IW-1:0]    td_q[$];
  int   acc_total = 0;
  int   pops = 0;
  int   m_idx = 0;
  bit   new_trace = 1'b1;
  logic prev_am_reset = 1'b1;
  logic prev_td = 1'b0;

  always @(negedge clk) begin
    logic [NR-1:0]    r;
    logic [NR+IW-1:0] e;
    if (reset) begin
      exp_q.delete();
      new_trace = 1'b1;
    end else begin
      if (s_valid && s_ready) begin
        acc_total++;
        if (new_trace || s_first) m_idx = 0;
        else if (m_idx < 15) m_idx = m_idx + 1;
        new_trace = s_last;
        r = rep_map(s_data);
        if (r != '0) exp_q.push_back({r, 4'(m_idx)});
      end
      if (m_valid && m_ready) begin
        pops++;
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL sb_unexpected: got record %0h/%0h expected none", m_report, m_index);
        end else begin
          e = exp_q.pop_front();
          check("sb_report", 32'(m_report), 32'(e[NR+IW-1:IW]));
          check("sb_index", 32'(m_index), 32'(e[IW-1:0]));
        end
      end
      if (!am_reset && prev_am_reset) check("start_align", 32'(am_run), 32'd1);
      if (trace_done) begin
        check("done_pulse_width", 32'(prev_td), 32'd0);
        td_q.push_back(trace_len);
      end
    end
    prev_am_reset = am_reset;
    prev_td = trace_done;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] tx [32];

  task automatic send_trace(input int n, input int stop_after, input bit with_last);
    bit ok;
    int cyc;
    for (int i = 0; i < n && i < stop_after; i++) begin
      s_valid = 1'b1;
      s_data  = tx[i];
      s_first = (i == 0);
      s_last  = with_last && (i == n - 1);
      ok = 1'b0;
      cyc = 0;
      while (!ok && cyc < 40) begin
        @(negedge clk);
        ok = s_ready;
        @(posedge clk);
        #1;
        cyc++;
      end
      if (!ok) begin
        n_checks++; n_fail++;
        $display("FAIL send_timeout: symbol %0d not accepted, s_ready %0b required 1", i, s_ready);
      end
    end
    s_valid = 1'b0;
    s_first = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int cyc = 0;
    while (td_q.size() < target && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    @(posedge clk);
    #1;
    check("trace_done_seen", 32'(td_q.size()), 32'(target));
  endtask

  task automatic reset_and_check(input string tag);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_am_reset"}, 32'(am_reset), 32'd1);
    check({tag, "_am_run"}, 32'(am_run), 32'd0);
    check({tag, "_am_symbols"}, 32'(am_symbols), 32'd0);
    check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    check({tag, "_trace_done"}, 32'(trace_done), 32'd0);
    check({tag, "_trace_len"}, 32'(trace_len), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic v; logic [7:0] d; logic f; logic l; logic mr;
    logic e_rdy; logic e_amr; logic e_run; logic [7:0] e_sym;
    logic e_mv; logic [3:0] e_rep; logic [3:0] e_idx;
    logic e_td; logic [3:0] e_len; logic e_busy;
  } vec_t;

  function automatic vec_t mk(input int v, d, f, l, mr, rdy, amr, run, sym,
                              mv, rep, idx, td, len, bsy);
    vec_t x;
    x.v = 1'(v); x.d = 8'(d); x.f = 1'(f); x.l = 1'(l); x.mr = 1'(mr);
    x.e_rdy = 1'(rdy); x.e_amr = 1'(amr); x.e_run = 1'(run); x.e_sym = 8'(sym);
    x.e_mv = 1'(mv); x.e_rep = 4'(rep); x.e_idx = 4'(idx);
    x.e_td = 1'(td); x.e_len = 4'(len); x.e_busy = 1'(bsy);
    return x;
  endfunction

  vec_t tbl [10];

  initial begin
    int base;
    int pops0;
    //             v  d    f  l  mr  rdy amr run sym  mv rep idx td len busy
    tbl[0] = mk(1, 'h10, 1, 0, 0,  0,  1,  0,  'h00, 0, 0, 0,  0, 0,  0);
    tbl[1] = mk(1, 'h10, 1, 0, 0,  0,  1,  0,  'h00, 0, 0, 0,  0, 0,  1);
    tbl[2] = mk(1, 'h10, 1, 0, 0,  1,  1,  0,  'h00, 0, 0, 0,  0, 0,  1);
    tbl[3] = mk(1, 'h20, 0, 0, 0,  1,  0,  1,  'h10, 0, 0, 0,  0, 0,  1);
    tbl[4] = mk(1, 'h30, 0, 1, 0,  1,  0,  1,  'h20, 0, 0, 0,  0, 0,  1);
    tbl[5] = mk(0, 'h00, 0, 0, 0,  0,  0,  1,  'h30, 0, 0, 0,  0, 0,  1);
    tbl[6] = mk(0, 'h00, 0, 0, 0,  0,  0,  0,  'h30, 1, 2, 1,  0, 0,  1);
    tbl[7] = mk(0, 'h00, 0, 0, 0,  0,  1,  0,  'h30, 1, 2, 1,  1, 3,  0);
    tbl[8] = mk(0, 'h00, 0, 0, 1,  0,  1,  0,  'h30, 1, 2, 1,  0, 0,  0);
    tbl[9] = mk(0, 'h00, 0, 0, 0,  0,  1,  0,  'h30, 0, 0, 0,  0, 0,  0);

    reset = 1'b1; s_valid = 1'b0; s_data = '0; s_first = 1'b0; s_last = 1'b0;
    m_ready = 1'b0;
    @(posedge clk);
    #1;
    reset_and_check("rst");

    // Single three-symbol trace, cycle by cycle.
    rep_mode = 0;
    for (int i = 0; i < 10; i++) begin
      s_valid = tbl[i].v; s_data = tbl[i].d; s_first = tbl[i].f;
      s_last = tbl[i].l; m_ready = tbl[i].mr;
      @(negedge clk);
      check($sformatf("t%0d_s_ready", i), 32'(s_ready), 32'(tbl[i].e_rdy));
      check($sformatf("t%0d_am_reset", i), 32'(am_reset), 32'(tbl[i].e_amr));
      check($sformatf("t%0d_am_run", i), 32'(am_run), 32'(tbl[i].e_run));
      check($sformatf("t%0d_am_symbols", i), 32'(am_symbols), 32'(tbl[i].e_sym));
      check($sformatf("t%0d_m_valid", i), 32'(m_valid), 32'(tbl[i].e_mv));
      check($sformatf("t%0d_trace_done", i), 32'(trace_done), 32'(tbl[i].e_td));
      check($sformatf("t%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      if (tbl[i].e_mv) begin
        check($sformatf("t%0d_m_report", i), 32'(m_report), 32'(tbl[i].e_rep));
        check($sformatf("t%0d_m_index", i), 32'(m_index), 32'(tbl[i].e_idx));
      end
      if (tbl[i].e_td) check($sformatf("t%0d_trace_len", i), 32'(trace_len), 32'(tbl[i].e_len));
      @(posedge clk);
      #1;
    end
    m_ready = 1'b0;
    td_q.delete();

    // Backpressure: eight reporting symbols, consumer stalled.
    rep_mode = 1;
    for (int i = 0; i < 8; i++) tx[i] = 8'(8'h40 + i);
    base = acc_total;
    pops0 = pops;
    fork
      send_trace(8, 8, 1'b1);
      begin
        repeat (14) @(negedge clk);
        check("bp_accepted", 32'(acc_total - base), 32'd4);
        check("bp_s_ready_low", 32'(s_ready), 32'd0);
        check("bp_m_valid", 32'(m_valid), 32'd1);
        check("bp_head_index", 32'(m_index), 32'd0);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
      end
    join
    wait_done(1);
    check("bp_trace_len", 32'(td_q[0]), 32'd8);
    repeat (6) @(posedge clk);
    #1;
    check("bp_pops", 32'(pops - pops0), 32'd8);
    check("bp_fifo_empty", 32'(m_valid), 32'd0);
    td_q.delete();

    // Back-to-back: a new first symbol ends an unterminated trace.
    rep_mode = 2;
    tx[0] = 8'h01; tx[1] = 8'h02; tx[2] = 8'h03;
    send_trace(3, 3, 1'b0);
    tx[0] = 8'h04; tx[1] = 8'h05;
    send_trace(2, 2, 1'b1);
    wait_done(2);
    check("b2b_len_a", 32'(td_q[0]), 32'd3);
    check("b2b_len_b", 32'(td_q[1]), 32'd2);
    repeat (6) @(posedge clk);
    #1;
    check("b2b_fifo_empty", 32'(m_valid), 32'd0);
    check("b2b_idle", 32'(busy), 32'd0);
    td_q.delete();

    // Index saturation with a 20-symbol trace.
    for (int i = 0; i < 20; i++) tx[i] = 8'h0F;
    send_trace(20, 20, 1'b1);
    wait_done(1);
    check("sat_trace_len", 32'(td_q[0]), 32'd15);
    repeat (8) @(posedge clk);
    #1;
    check("sat_fifo_empty", 32'(m_valid), 32'd0);
    td_q.delete();

    // Reset after five accepted symbols with two records pending.
    m_ready = 1'b0;
    tx[0] = 8'h01; tx[1] = 8'h00; tx[2] = 8'h02; tx[3] = 8'h00;
    tx[4] = 8'h00; tx[5] = 8'h03; tx[6] = 8'h04; tx[7] = 8'h05;
    send_trace(8, 5, 1'b1);
    @(negedge clk);
    check("mr_pending_valid", 32'(m_valid), 32'd1);
    check("mr_pending_report", 32'(m_report), 32'd1);
    check("mr_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    reset_and_check("mr");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("mr_no_done_%0d", i), 32'(trace_done), 32'd0);
      check($sformatf("mr_no_push_%0d", i), 32'(m_valid), 32'd0);
    end
    check("mr_done_count", 32'(td_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ltl_monitor_sequencer.md
LTL_MONITOR_SEQUENCER -- requirements
Module: ltl_monitor_sequencer

Interface
REQ-001 SHALL have parameter NUM_REPORTS, default 4, width of the automaton report vector.
REQ-002 SHALL have parameter IDX_W, default 16, width of the symbol index and trace length.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, report FIFO entries (power of two, >=4).
REQ-004 SHALL use one clock and a synchronous, active-high reset, with the following ports (name, direction, width, meaning):
- clk  in  1  clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- s_valid  in  1  symbol valid.
- s_ready  out  1  symbol accepted when s_valid&&s_ready.
- s_data  in  8  trace symbol.
- s_first  in  1  symbol is the first of a trace.
- s_last  in  1  symbol is the last of a trace.
- am_reset  out  1  automaton reset.
- am_run  out  1  automaton step enable.
- am_symbols  out  8  automaton symbol.
- am_report  in  NUM_REPORTS  automaton report-state outputs.
- m_valid  out  1  report record valid.
- m_ready  in  1  report record consumed.
- m_report  out  NUM_REPORTS  captured report vector.
- m_index  out  IDX_W  index of the symbol that produced the report.
- trace_done  out  1  one-cycle end-of-trace pulse.
- trace_len  out  IDX_W  symbols in the finished trace, valid with trace_done.
- busy  out  1  state != IDLE.

Function
REQ-005 SHALL implement states IDLE, FLUSH, RUN, DRAIN.
REQ-006 IDLE:
- am_reset=1, s_ready=0.
- Goes to FLUSH when s_valid=1, regardless of s_first.
REQ-007 FLUSH:
- am_reset=1.
- s_ready=1 only from the 2nd FLUSH cycle onward, and only if the FIFO has >=2 free entries.
- A symbol accepted with s_first=0 in FLUSH is still treated as trace start.
REQ-008 On accepting the first symbol in FLUSH:
- Next cycle: am_reset=0, am_run=1, am_symbols=that symbol, index counter=0.
- State goes to RUN.
- The first am_run pulse therefore coincides with the first cycle after am_reset falls.
REQ-009 am_run and am_symbols SHALL be registered.
- am_run=1 for exactly one cycle per accepted symbol; am_run=0 otherwise.
- am_symbols holds its last value when am_run=0.
REQ-010 RUN: s_ready=1 iff the FIFO has >=2 free entries and s_first=0.
- s_valid=1 with s_first=1 in RUN (no preceding s_last) ends the current trace: go to DRAIN, then FLUSH instead of IDLE.
REQ-011 The symbol index increments by 1 for each am_run pulse after the first and saturates at 2^IDX_W-1.
REQ-012 am_report SHALL be sampled exactly one cycle after each am_run pulse and tagged with that pulse's index.
- A sampled vector !=0 pushes {vector, index} into the FIFO.
- A zero vector pushes nothing.
REQ-013 Accepting a symbol with s_last=1 SHALL move RUN to DRAIN (FLUSH to DRAIN if it is also the first symbol).
REQ-014 DRAIN:
- s_ready=0.
- Waits until the last symbol's report sample has completed, i.e. 2 cycles after the last acceptance.
- Then pulses trace_done with trace_len = last index + 1 (saturating), and goes to IDLE, or to FLUSH per REQ-010.
REQ-015 FIFO:
- First-word fall-through; m_valid = FIFO non-empty.
- Pop on m_valid&&m_ready.
- Simultaneous push and pop when full or empty is legal and preserves order and count.
- Pointers wrap modulo FIFO_DEPTH.
REQ-016 The s_ready rule of REQ-007/REQ-010 SHALL guarantee no push into a full FIFO; no reports are ever dropped.
REQ-017 FIFO contents and m_valid SHALL persist across trace boundaries, IDLE and FLUSH; they are cleared only by reset.

Reset
REQ-018 While reset=1 the block SHALL force:
- state=IDLE, am_reset=1, am_run=0, am_symbols=0.
- s_ready=0, m_valid=0, FIFO empty, pointers=0.
- index=0, trace_done=0, trace_len=0, busy=0.
REQ-019 Reset asserted mid-trace SHALL abandon the trace without a trace_done pulse or any FIFO push in the cycle after reset.

Verification
REQ-020 Single trace:
- Stimulus: 3 symbols {0x10,0x20,0x30} (first, -, last); automaton reports 4'b0010 after the 2nd symbol only.
- Response: one record {0010, idx=1}; trace_done with trace_len=3; return to IDLE.
REQ-021 Start alignment:
- Stimulus: any trace.
- Response: the first am_run=1 occurs in the same cycle am_reset first reads 0; s_ready=0 in the first FLUSH cycle.
REQ-022 Backpressure:
- Stimulus: m_ready=0, every symbol reports 4'b1000, 8-symbol trace.
- Response: s_ready drops when free entries <2; FIFO reaches exactly 4 entries; no record lost; after m_ready=1, indices 0..7 are delivered in order.
REQ-023 Back-to-back traces:
- Stimulus: a new s_first symbol arrives in RUN without s_last.
- Response: DRAIN, trace_done with the correct trace_len, FLUSH, new trace indexed from 0.
REQ-024 Reset mid-RUN:
- Stimulus: reset after 5 accepted symbols with 2 FIFO records pending.
- Response: all outputs at REQ-018 values the next cycle; no trace_done pulse.
REQ-025 Index saturation:
- Stimulus: IDX_W=4 with a 20-symbol trace.
- Response: index holds at 15; trace_len=15.
